icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL provide the port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL provide the port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL provide the port imemREN, input, 1 bit: datapath instruction read request.
REQ-004 The block SHALL provide the port imemaddr, input, 32 bits: datapath instruction byte address, word aligned.
REQ-005 The block SHALL provide the port imemload, output, 32 bits: instruction returned to the datapath.
REQ-006 The block SHALL provide the port ihit, output, 1 bit: imemload is valid this cycle.
REQ-007 The block SHALL provide the port iREN, output, 1 bit: read request to the memory controller.
REQ-008 The block SHALL provide the port iaddr, output, 32 bits: memory read address.
REQ-009 The block SHALL provide the port iload, input, 32 bits: memory read data.
REQ-010 The block SHALL provide the port iwait, input, 1 bit: memory busy; iload is valid in a cycle where iREN=1 and iwait=0.

Function
REQ-011 Organisation SHALL be direct-mapped, 16 frames, one 32-bit word per frame; each frame holds a valid bit, a 26-bit tag and a data word.
REQ-012 Address split SHALL be tag = imemaddr[31:6], index = imemaddr[5:2]; imemaddr[1:0] SHALL be ignored.
REQ-013 FSM states SHALL be IDLE and FILL.
REQ-014 In IDLE, hit = imemREN and valid[index] and (tag[index] == imemaddr[31:6]).
REQ-015 On a hit in IDLE: ihit=1 and imemload=data[index] in the same cycle, with zero-cycle latency; the state SHALL remain IDLE and iREN=0.
REQ-016 In IDLE, imemREN=1 with no hit SHALL latch imemaddr into a miss-address register and move to FILL on the next edge; in that cycle ihit=0.
REQ-017 In FILL: iREN=1, iaddr=miss-address register, ihit=0, and imemload=0.
REQ-018 In FILL with iwait=0, the block SHALL write iload, the latched tag and valid=1 into the latched index, then return to IDLE on the same edge; the re-presented address then hits the following cycle.
REQ-019 Miss latency (request to ihit) SHALL be 1 + memory wait cycles + 1 cycles.
REQ-020 Once entered, FILL SHALL complete for the latched address even if imemREN drops or imemaddr changes, for example on a branch flush.
REQ-021 A fill to an occupied index SHALL overwrite (evict) that frame unconditionally.
REQ-022 When not in FILL: iREN=0 and iaddr=imemaddr.
REQ-023 When ihit=0 in IDLE: imemload=0.
REQ-024 imemREN=0 in IDLE SHALL cause no state change and ihit=0.

Reset
REQ-025 While nRST=0, the block SHALL clear all valid bits, tags and data, set the state to IDLE and clear the miss-address register, asynchronously.
REQ-026 After reset, the outputs SHALL be ihit=0, imemload=0 and iREN=0, with iaddr following imemaddr.
REQ-027 If reset is asserted during FILL, the fill SHALL be abandoned and no frame written; the next request SHALL miss.

Verification
REQ-028 Cold miss: after reset, imemREN=1 with imemaddr=0x00000040 and iwait=1 for 3 cycles, then iload=0x8C010004 with iwait=0. Required response: iREN=1 and iaddr=0x40 for 4 cycles, then ihit=1 with imemload=0x8C010004 on the next cycle.
REQ-029 Repeat hit: a second request to 0x40 SHALL give ihit=1 in the same cycle with iREN=0.
REQ-030 Conflict: after 0x40 is filled, a request to 0x00000080 (same index 0, different tag) SHALL miss and fill; a subsequent request to 0x40 SHALL miss again.
REQ-031 Abandoned request: in FILL, drop imemREN and change imemaddr to 0x100. Required response: iaddr stays 0x40 until iwait=0, frame 0 is filled with tag for 0x40, and the state returns to IDLE.
REQ-032 Reset mid-fill: assert nRST=0 in FILL. Required response: iREN=0 immediately, and a request to the same address afterwards misses.
REQ-033 Full sweep: fill all 16 indices with addresses 0x00..0x3C, then re-read each. Required response: all 16 requests hit, with imemload matching the filled data.

Source files
------------

// File: rtl/icache_if.sv
// Bus between the instruction cache, the datapath fetch stage and the memory controller.
// The slave modport is the cache; the master modport is the surrounding system.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  modport slave (
    input  imemREN, imemaddr, iload, iwait,
    output imemload, ihit, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iload, iwait,
    input  imemload, ihit, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 one-word frames, zero-latency hits,
// blocking single-word refill from the memory controller.
module icache (
  input  logic     CLK,
  input  logic     nRST,
  icache_if.slave  bus
);
  typedef enum logic {IDLE, FILL} state_t;

  state_t      state_q, state_d;
  logic [31:0] miss_addr_q, miss_addr_d;
  logic        valid_q [16];
  logic        valid_d [16];
  logic [25:0] tag_q   [16];
  logic [25:0] tag_d   [16];
  logic [31:0] data_q  [16];
  logic [31:0] data_d  [16];

  logic [3:0]  req_idx;
  logic [3:0]  fill_idx;
  logic        hit;

  assign req_idx  = bus.imemaddr[5:2];
  assign fill_idx = miss_addr_q[5:2];
  assign hit      = (state_q == IDLE) && bus.imemREN && valid_q[req_idx]
                    && (tag_q[req_idx] == bus.imemaddr[31:6]);

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    bus.ihit     = hit;
    bus.imemload = hit ? data_q[req_idx] : 32'h0;
    bus.iREN     = 1'b0;
    bus.iaddr    = bus.imemaddr;
    case (state_q)
      IDLE: begin
        if (bus.imemREN && !hit) begin
          miss_addr_d = bus.imemaddr;
          state_d     = FILL;
        end
      end
      FILL: begin
        // The fill runs off the latched address, so a flush on the fetch side cannot redirect it.
        bus.iREN  = 1'b1;
        bus.iaddr = miss_addr_q;
        if (!bus.iwait) begin
          valid_d[fill_idx] = 1'b1;
          tag_d[fill_idx]   = miss_addr_q[31:6];
          data_d[fill_idx]  = bus.iload;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= 32'h0;
      for (int i = 0; i < 16; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= 26'h0;
        data_q[i]  <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Randomised scoreboard bench for icache against a resident-word reference model and a
// variable-latency memory model.
module tb_icache;
  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  icache_if bus ();
  icache dut (.CLK(clk), .nRST(nrst), .bus(bus.slave));

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          mem_wait = 0;
  int          mcnt = 0;
  logic [31:0] pending_addr = 32'h0;
  logic        ref_vld  [16];
  logic [29:0] ref_word [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w == 32'h40) return 32'h8C010004;
    return (w * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  function automatic bit ref_hit(input logic [31:0] a);
    return ref_vld[a[5:2]] && (ref_word[a[5:2]] == a[31:2]);
  endfunction

  task automatic ref_fill(input logic [31:0] a);
    ref_vld[a[5:2]]  = 1'b1;
    ref_word[a[5:2]] = a[31:2];
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 16; i++) begin
      ref_vld[i]  = 1'b0;
      ref_word[i] = 30'h0;
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory controller: holds iwait for mem_wait cycles of each request, then returns the word.
  always @(posedge clk) begin
    #1;
    if (bus.iREN) begin
      if (mcnt < mem_wait) begin
        bus.iwait = 1'b1;
        bus.iload = $urandom;
        mcnt++;
      end else begin
        bus.iwait = 1'b0;
        bus.iload = mem_word(bus.iaddr);
      end
    end else begin
      mcnt      = 0;
      bus.iwait = 1'b1;
      bus.iload = $urandom;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.iREN) chk("iaddr_fill", bus.iaddr, pending_addr);
    else          chk("iaddr_pass", bus.iaddr, bus.imemaddr);
    if (bus.ihit) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_hit: ihit=1 for addr %h, required ihit=0", bus.imemaddr);
      end else begin
        e = exp_q.pop_front();
        chk("hit_data", bus.imemload, e.data);
        chk("hit_latency", cyc - start_cyc, e.lat);
      end
    end else begin
      chk("miss_load_zero", bus.imemload, 32'h0);
    end
  end

  task automatic do_req(input logic [31:0] a, input int w);
    bit h;
    bit got;
    exp_t e;
    @(posedge clk); #1;
    h = ref_hit(a);
    e.data = mem_word(a);
    e.lat  = h ? 0 : w + 2;
    exp_q.push_back(e);
    if (!h) ref_fill(a);
    mem_wait     = w;
    pending_addr = a;
    start_cyc    = cyc;
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = bus.ihit;
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL req_timeout: addr %h got no ihit, required ihit=1", a);
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.imemREN  = 1'b0;
    bus.imemaddr = $urandom;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          got;
    logic [31:0] a;
    ref_clear();
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h1234;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0;
    #2 nrst = 1'b0;
    @(negedge clk);
    chk("rst_ihit", {31'h0, bus.ihit}, 32'h0);
    chk("rst_imemload", bus.imemload, 32'h0);
    chk("rst_iREN", {31'h0, bus.iREN}, 32'h0);
    chk("rst_iaddr", bus.iaddr, 32'h1234);
    @(posedge clk); #3 nrst = 1'b1;

    do_req(32'h40, 3);
    do_req(32'h40, 0);
    do_req(32'h80, 2);
    do_req(32'h40, 1);
    do_req(32'h80, 0);

    // Flushed request: the fill for 0x40 must still complete and land in frame 0.
    @(posedge clk); #1;
    mem_wait     = 3;
    pending_addr = 32'h40;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    @(posedge clk); #1;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h100;
    chk("abandon_iREN", {31'h0, bus.iREN}, 32'h1);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = !bus.iREN;
    end
    chk("abandon_done", {31'h0, got}, 32'h1);
    ref_fill(32'h40);
    do_req(32'h40, 0);
    do_req(32'h100, 1);
    do_req(32'h40, 0);

    // Reset during a fill: no frame may be written.
    @(posedge clk); #1;
    mem_wait     = 5;
    pending_addr = 32'h80;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h80;
    @(posedge clk); #2;
    nrst = 1'b0;
    #1;
    chk("midfill_rst_iREN", {31'h0, bus.iREN}, 32'h0);
    bus.imemREN = 1'b0;
    ref_clear();
    repeat (2) @(negedge clk);
    @(posedge clk); #3 nrst = 1'b1;
    do_req(32'h80, 2);

    for (int i = 0; i < 16; i++) do_req(32'(i * 4), int'($urandom_range(0, 3)));
    for (int i = 0; i < 16; i++) do_req(32'(i * 4), 0);

    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      do_req(a, int'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
